irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Machine-mode interrupt controller sitting directly downstream of the system timer. It consumes the timer's `irq_mtimecmp` level, an external interrupt line and a software interrupt bit. It owns the `mstatus.MIE/MPIE`, `mie` and `mip` CSR bits. It presents a single prioritised trap request, with a handshake, to the pipeline's trap/commit logic.

## Interface
- No parameters.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `irq_mtimecmp` in 1: timer compare level from the system timer.
- `irq_ext` in 1: external interrupt level.
- `csr_addr` in 12: CSR address from execute stage.
- `csr_we` in 1: CSR write strobe, one cycle per write.
- `csr_wdata` in 32: CSR write data, already resolved for CSRRW/S/C.
- `csr_rdata` out 32: CSR read data, combinational from `csr_addr`.
- `int_req` out 1: trap request to the pipeline.
- `int_cause` out 32: `mcause` value for the request; valid while `int_req` is high.
- `int_ack` in 1: pipeline took the trap this cycle.
- `mret` in 1: pipeline committed MRET this cycle.

## Operation
- CSR map. Unmapped addresses read 0 and ignore writes.
  - `mstatus` 0x300: bit3 MIE RW, bit7 MPIE RW; other bits read 0.
  - `mie` 0x304: bit3 MSIE, bit7 MTIE, bit11 MEIE, all RW.
  - `mip` 0x344: bit3 MSIP RW; bit7 MTIP and bit11 MEIP read-only, and writes to them are ignored.
- `mip` update each cycle: MTIP <= `irq_mtimecmp`; MEIP <= synchronised `irq_ext`; MSIP changes only on CSR write.
- Pending set = `mip & mie`, gated by MIE.
- Priority order and cause values:
  - MEI: 0x8000000B (highest)
  - MSI: 0x80000003
  - MTI: 0x80000007 (lowest)
- FSM, states IDLE and REQ:
  - IDLE: `int_req`=0. If the gated pending set is non-zero: latch the highest-priority cause into `int_cause`, go to REQ.
  - REQ: `int_req`=1 and `int_cause` is frozen. A higher-priority arrival does not re-rank.
  - REQ with `int_ack`: MPIE <= MIE, MIE <= 0, go to IDLE.
  - REQ without `int_ack`, when the latched source's gated pending bit drops (source cleared, mie bit cleared, or MIE cleared by CSR write): withdraw, go to IDLE the next cycle. A different still-pending source is re-evaluated from IDLE.
- `mret`: MIE <= MPIE, MPIE <= 1.
- Simultaneous-event priority:
  - `int_ack` beats `mret` and beats a CSR write to `mstatus` in the same cycle.
  - `mret` beats a CSR write to `mstatus`.
  - A CSR write to `mie`/`mip` takes effect regardless.
- `int_ack` in IDLE is ignored; no state change.

## Timing
- Reset values:
  - `int_req`=0, `int_cause`=0.
  - MIE=0, MPIE=0; `mie`=0; `mip`=0.
  - FSM=IDLE; synchroniser flops=0.
- `csr_rdata` is combinational. A write is visible on read the next cycle.
- Latency from `irq_mtimecmp` rising to `int_req`, with enables set: 2 cycles (cycle 1: MTIP captured; cycle 2: REQ).
- `irq_ext` latency: 4 cycles with the synchroniser compiled in, 2 without.
- After `int_ack`, `int_req` is low the next cycle. It cannot reassert until MIE returns to 1.
- Reset mid-REQ drops `int_req` asynchronously.

## Configuration
- `IRQ_CTRL_EXT_SYNC_EN`
  - Defined: `irq_ext` passes through a 2-flop synchroniser before MEIP. It is treated as asynchronous.
  - Undefined: `irq_ext` feeds MEIP directly. It must be synchronous to `clk`.

## Structure
- Shared package holds:
  - CSR address constants (0x300, 0x304, 0x344).
  - Bit positions 3/7/11.
  - Cause constants.
  - FSM state typedef.
- One sub-module, `irq_sync2`: 2-flop synchroniser with async active-high reset to 0. It is instantiated only under `IRQ_CTRL_EXT_SYNC_EN`.

## Test plan
- Timer interrupt: mie=0x80 and MIE=1, then `irq_mtimecmp` rises.
  - `int_req`=1 two cycles later with `int_cause`=0x80000007.
  - After `int_ack`: mstatus reads 0x80.
- Priority: MTI and MEI rise together, all enables set.
  - `int_cause`=0x8000000B, and it stays frozen while MTI remains pending.
- Withdraw: request in REQ, then CSR write mie=0 before ack.
  - `int_req` falls the next cycle; no MIE change.
- MRET restore: after an acked trap (mstatus=0x80), assert `mret`.
  - mstatus reads 0x88.
  - A pending MTI re-raises `int_req` 1 cycle later.
- Software interrupt:
  - Write mip=0x8 with mie=0x8 and MIE=1: cause 0x80000003.
  - Write mip=0x888: reads back 0x8 plus live MTIP/MEIP only.
- Simultaneous events and reset:
  - `int_ack` together with a CSR write mstatus=0x8: MIE=0 wins.
  - Assert `reset` mid-REQ: all outputs return to 0 immediately.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared constants, types and priority helpers for the machine-mode interrupt controller.
package irq_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam int BIT_MIE  = 3;
  localparam int BIT_MPIE = 7;
  localparam int BIT_MSI  = 3;
  localparam int BIT_MTI  = 7;
  localparam int BIT_MEI  = 11;

  localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
  localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
  localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } irq_state_e;

  typedef struct packed {
    logic mei;
    logic msi;
    logic mti;
  } irq_pend_t;

  function automatic logic [31:0] prio_cause(input irq_pend_t p);
    logic [31:0] c;
    if (p.mei) begin
      c = CAUSE_MEI;
    end else if (p.msi) begin
      c = CAUSE_MSI;
    end else if (p.mti) begin
      c = CAUSE_MTI;
    end else begin
      c = 32'h0;
    end
    return c;
  endfunction

  // True while the source behind a latched cause is still gated-pending.
  function automatic logic src_live(input logic [31:0] cause, input irq_pend_t p);
    logic v;
    case (cause)
      CAUSE_MEI: v = p.mei;
      CAUSE_MSI: v = p.msi;
      CAUSE_MTI: v = p.mti;
      default:   v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/irq_ctrl_sync2.sv
// irq_sync2: two-flop level synchroniser, asynchronously reset to 0.
module irq_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Synchroniser chain.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: machine-mode interrupt controller owning mstatus.MIE/MPIE, mie and mip.
// Define IRQ_CTRL_EXT_SYNC_EN to pass irq_ext through a 2-flop synchroniser.
module irq_ctrl
  import irq_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        irq_mtimecmp,
  input  logic        irq_ext,
  input  logic [11:0] csr_addr,
  input  logic        csr_we,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        int_req,
  output logic [31:0] int_cause,
  input  logic        int_ack,
  input  logic        mret
);

  logic        w_ext;
  logic        r_mstatus_mie;
  logic        r_mstatus_mpie;
  logic        r_msie;
  logic        r_mtie;
  logic        r_meie;
  logic        r_msip;
  logic        r_mtip;
  logic        r_meip;
  irq_state_e  r_state;
  irq_state_e  w_next_state;
  logic        r_int_req;
  logic [31:0] r_int_cause;
  logic [31:0] w_next_cause;
  logic        w_ack_take;
  irq_pend_t   w_pend;
  logic        w_wr_mstatus;
  logic        w_wr_mie;
  logic        w_wr_mip;
  logic [31:0] w_rdata;
  logic        w_unused;

`ifdef IRQ_CTRL_EXT_SYNC_EN
  irq_sync2 u_ext_sync (
    .i_clk (clk),
    .i_rst (reset),
    .i_d   (irq_ext),
    .o_q   (w_ext)
  );
`else
  assign w_ext = irq_ext;
`endif

  assign w_wr_mstatus = csr_we && (csr_addr == CSR_MSTATUS);
  assign w_wr_mie     = csr_we && (csr_addr == CSR_MIE);
  assign w_wr_mip     = csr_we && (csr_addr == CSR_MIP);

  assign w_pend.mei = r_mstatus_mie & r_meip & r_meie;
  assign w_pend.msi = r_mstatus_mie & r_msip & r_msie;
  assign w_pend.mti = r_mstatus_mie & r_mtip & r_mtie;

  assign w_unused = ^{csr_wdata[31:12], csr_wdata[10:8], csr_wdata[6:4], csr_wdata[2:0]};

  // mstatus: trap entry beats mret, which beats a CSR write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
    end else if (w_ack_take) begin
      r_mstatus_mpie <= r_mstatus_mie;
      r_mstatus_mie  <= 1'b0;
    end else if (mret) begin
      r_mstatus_mie  <= r_mstatus_mpie;
      r_mstatus_mpie <= 1'b1;
    end else if (w_wr_mstatus) begin
      r_mstatus_mie  <= csr_wdata[BIT_MIE];
      r_mstatus_mpie <= csr_wdata[BIT_MPIE];
    end
  end

  // mie enables and mip pending bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_msie <= 1'b0;
      r_mtie <= 1'b0;
      r_meie <= 1'b0;
      r_msip <= 1'b0;
      r_mtip <= 1'b0;
      r_meip <= 1'b0;
    end else begin
      r_mtip <= irq_mtimecmp;
      r_meip <= w_ext;
      if (w_wr_mie) begin
        r_msie <= csr_wdata[BIT_MSI];
        r_mtie <= csr_wdata[BIT_MTI];
        r_meie <= csr_wdata[BIT_MEI];
      end
      if (w_wr_mip) begin
        r_msip <= csr_wdata[BIT_MSI];
      end
    end
  end

  // FSM state and registered request outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_int_req   <= 1'b0;
      r_int_cause <= 32'h0;
    end else begin
      r_state     <= w_next_state;
      r_int_req   <= (w_next_state == ST_REQ);
      r_int_cause <= w_next_cause;
    end
  end

  // Next state: latch cause once, then wait for ack or withdraw.
  always_comb begin
    w_next_state = r_state;
    w_next_cause = r_int_cause;
    w_ack_take   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_pend) begin
          w_next_state = ST_REQ;
          w_next_cause = prio_cause(w_pend);
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (int_ack) begin
          w_ack_take   = 1'b1;
          w_next_state = ST_IDLE;
        end else if (!src_live(r_int_cause, w_pend)) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_REQ;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // CSR read mux.
  always_comb begin
    w_rdata = 32'h0;
    case (csr_addr)
      CSR_MSTATUS: begin
        w_rdata[BIT_MIE]  = r_mstatus_mie;
        w_rdata[BIT_MPIE] = r_mstatus_mpie;
      end
      CSR_MIE: begin
        w_rdata[BIT_MSI] = r_msie;
        w_rdata[BIT_MTI] = r_mtie;
        w_rdata[BIT_MEI] = r_meie;
      end
      CSR_MIP: begin
        w_rdata[BIT_MSI] = r_msip;
        w_rdata[BIT_MTI] = r_mtip;
        w_rdata[BIT_MEI] = r_meip;
      end
      default: begin
        w_rdata = 32'h0;
      end
    endcase
  end

  assign csr_rdata = w_rdata;
  assign int_req   = r_int_req;
  assign int_cause = r_int_cause;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: scenario tasks push expectations into a scoreboard.
module tb_irq_ctrl;

  logic        clk;
  logic        reset;
  logic        irq_mtimecmp;
  logic        irq_ext;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        int_req;
  logic [31:0] int_cause;
  logic        int_ack;
  logic        mret;

  int n_tests;
  int n_fail;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  string       nm_q[$];

  irq_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .irq_mtimecmp (irq_mtimecmp),
    .irq_ext      (irq_ext),
    .csr_addr     (csr_addr),
    .csr_we       (csr_we),
    .csr_wdata    (csr_wdata),
    .csr_rdata    (csr_rdata),
    .int_req      (int_req),
    .int_cause    (int_cause),
    .int_ack      (int_ack),
    .mret         (mret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    csr_we    = 1'b1;
    csr_addr  = a;
    csr_wdata = d;
    tick();
    csr_we    = 1'b0;
    csr_wdata = 32'h0;
  endtask

  task automatic csr_read(input logic [11:0] a, output logic [31:0] d);
    csr_addr = a;
    #1;
    d = csr_rdata;
  endtask

  task automatic expect_val(input string nm, input logic [31:0] v);
    nm_q.push_back(nm);
    exp_q.push_back(v);
  endtask

  task automatic observe(input logic [31:0] v);
    obs_q.push_back(v);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    expect_val("rst_int_req", 32'h0);   observe({31'h0, int_req});
    expect_val("rst_int_cause", 32'h0); observe(int_cause);
    expect_val("rst_mstatus", 32'h0);   csr_read(12'h300, d); observe(d);
    expect_val("rst_mie", 32'h0);       csr_read(12'h304, d); observe(d);
    expect_val("rst_mip", 32'h0);       csr_read(12'h344, d); observe(d);
    while (exp_q.size() > 0) begin
      logic [31:0] e;
      logic [31:0] o;
      string n;
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hDEAD_DEAD;
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", n, o, e);
      end
    end
  endtask

  task automatic test_timer_and_mret();
    logic [31:0] d;
    csr_write(12'h304, 32'h80);
    csr_write(12'h300, 32'h8);
    irq_mtimecmp = 1'b1;
    tick();
    expect_val("tmr_req_c1", 32'h0);         observe({31'h0, int_req});
    tick();
    expect_val("tmr_req_c2", 32'h1);         observe({31'h0, int_req});
    expect_val("tmr_cause", 32'h8000_0007);  observe(int_cause);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    expect_val("tmr_req_after_ack", 32'h0);  observe({31'h0, int_req});
    expect_val("tmr_mstatus_ack", 32'h80);   csr_read(12'h300, d); observe(d);
    tick();
    expect_val("tmr_no_rearm", 32'h0);       observe({31'h0, int_req});
    mret = 1'b1;
    tick();
    mret = 1'b0;
    expect_val("mret_mstatus", 32'h88);      csr_read(12'h300, d); observe(d);
    tick();
    expect_val("mret_rereq", 32'h1);         observe({31'h0, int_req});
    expect_val("mret_cause", 32'h8000_0007); observe(int_cause);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    irq_mtimecmp = 1'b0;
    tick();
    while (exp_q.size() > 0) begin
      logic [31:0] e;
      logic [31:0] o;
      string n;
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hDEAD_DEAD;
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", n, o, e);
      end
    end
  endtask

  task automatic test_priority();
    csr_write(12'h304, 32'h888);
    csr_write(12'h300, 32'h8);
    irq_mtimecmp = 1'b1;
    irq_ext      = 1'b1;
    tick();
    tick();
    expect_val("prio_req", 32'h1);          observe({31'h0, int_req});
    expect_val("prio_cause", 32'h8000_000B); observe(int_cause);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_val("prio_frozen", 32'h8000_000B); observe(int_cause);
    end
    int_ack = 1'b1;
    tick();
    int_ack      = 1'b0;
    irq_mtimecmp = 1'b0;
    irq_ext      = 1'b0;
    tick();
    tick();
    while (exp_q.size() > 0) begin
      logic [31:0] e;
      logic [31:0] o;
      string n;
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hDEAD_DEAD;
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", n, o, e);
      end
    end
  endtask

  task automatic test_withdraw();
    logic [31:0] d;
    csr_write(12'h300, 32'h8);
    irq_mtimecmp = 1'b1;
    tick();
    tick();
    expect_val("wd_req", 32'h1);            observe({31'h0, int_req});
    expect_val("wd_cause", 32'h8000_0007);  observe(int_cause);
    csr_write(12'h304, 32'h0);
    expect_val("wd_req_hold", 32'h1);       observe({31'h0, int_req});
    tick();
    expect_val("wd_req_drop", 32'h0);       observe({31'h0, int_req});
    expect_val("wd_mstatus", 32'h8);        csr_read(12'h300, d); observe(d);
    tick();
    expect_val("wd_stays_low", 32'h0);      observe({31'h0, int_req});
    irq_mtimecmp = 1'b0;
    tick();
    while (exp_q.size() > 0) begin
      logic [31:0] e;
      logic [31:0] o;
      string n;
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hDEAD_DEAD;
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", n, o, e);
      end
    end
  endtask

  task automatic test_swi();
    logic [31:0] d;
    csr_write(12'h304, 32'h8);
    csr_write(12'h344, 32'h8);
    tick();
    expect_val("swi_req", 32'h1);           observe({31'h0, int_req});
    expect_val("swi_cause", 32'h8000_0003); observe(int_cause);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    expect_val("swi_ack_drop", 32'h0);      observe({31'h0, int_req});
    irq_mtimecmp = 1'b1;
    csr_write(12'h344, 32'h888);
    expect_val("swi_mip_ro", 32'h88);       csr_read(12'h344, d); observe(d);
    irq_mtimecmp = 1'b0;
    irq_ext      = 1'b1;
    csr_write(12'h344, 32'h0);
    expect_val("swi_mip_live", 32'h800);    csr_read(12'h344, d); observe(d);
    expect_val("unmapped_rd", 32'h0);       csr_read(12'h345, d); observe(d);
    irq_ext = 1'b0;
    tick();
    while (exp_q.size() > 0) begin
      logic [31:0] e;
      logic [31:0] o;
      string n;
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hDEAD_DEAD;
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", n, o, e);
      end
    end
  endtask

  task automatic test_simultaneous_and_reset();
    logic [31:0] d;
    csr_write(12'h300, 32'h8);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    expect_val("idle_ack_mstatus", 32'h8);  csr_read(12'h300, d); observe(d);
    expect_val("idle_ack_req", 32'h0);      observe({31'h0, int_req});
    csr_write(12'h344, 32'h8);
    tick();
    expect_val("sim_req", 32'h1);           observe({31'h0, int_req});
    int_ack   = 1'b1;
    csr_we    = 1'b1;
    csr_addr  = 12'h300;
    csr_wdata = 32'h8;
    tick();
    int_ack = 1'b0;
    csr_we  = 1'b0;
    expect_val("ack_beats_wr_req", 32'h0);  observe({31'h0, int_req});
    expect_val("ack_beats_wr", 32'h80);     csr_read(12'h300, d); observe(d);
    mret      = 1'b1;
    csr_we    = 1'b1;
    csr_addr  = 12'h300;
    csr_wdata = 32'h0;
    tick();
    mret   = 1'b0;
    csr_we = 1'b0;
    expect_val("mret_beats_wr", 32'h88);    csr_read(12'h300, d); observe(d);
    tick();
    expect_val("pre_rst_req", 32'h1);       observe({31'h0, int_req});
    #2;
    reset = 1'b1;
    #1;
    expect_val("async_rst_req", 32'h0);     observe({31'h0, int_req});
    expect_val("async_rst_cause", 32'h0);   observe(int_cause);
    expect_val("async_rst_mstatus", 32'h0); csr_read(12'h300, d); observe(d);
    expect_val("async_rst_mip", 32'h0);     csr_read(12'h344, d); observe(d);
    tick();
    reset = 1'b0;
    tick();
    while (exp_q.size() > 0) begin
      logic [31:0] e;
      logic [31:0] o;
      string n;
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hDEAD_DEAD;
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", n, o, e);
      end
    end
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    reset        = 1'b1;
    irq_mtimecmp = 1'b0;
    irq_ext      = 1'b0;
    csr_addr     = 12'h0;
    csr_we       = 1'b0;
    csr_wdata    = 32'h0;
    int_ack      = 1'b0;
    mret         = 1'b0;
    tick();
    tick();
    test_reset();
    reset = 1'b0;
    tick();
    test_timer_and_mret();
    test_priority();
    test_withdraw();
    test_swi();
    test_simultaneous_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
